// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: drives the shared-bus source select, waits out memory
// latency for DRAM/IRAM sources, then pulses destination loads / DRAM write.
module bus_xfer_ctrl #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [2:0]       req_src,
    input  logic [6:0]       req_dst,
    output logic             req_ready,
    output logic [5:0]       control_register,
    output logic [1:0]       control_memory,
    output logic [5:0]       ld_en,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT, LOAD, ERR} state_t;

    state_t     state, next;
    logic [2:0] src_q;
    logic [6:0] dst_q;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       illegal;
    logic       mem_src;
    logic       drive_sel;

    assign accept  = req_valid && (state == IDLE);
    // DRAM is single-ported: it cannot be both source and write destination.
    assign illegal = (req_dst == 7'd0) || ((req_src == 3'd6) && req_dst[6]);
    assign mem_src = src_q[2] & src_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            wait_cnt   <= '0;
            xfer_count <= '0;
        end else begin
            state <= next;
            if (accept) begin
                src_q <= req_src;
                dst_q <= req_dst;
            end
            if (state == SETUP) begin
                wait_cnt <= 4'(MEM_LAT);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == LOAD) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next             = state;
        req_ready        = 1'b0;
        control_register = '0;
        control_memory   = '0;
        ld_en            = '0;
        mem_rd           = 1'b0;
        mem_wr           = 1'b0;
        done             = 1'b0;
        err              = 1'b0;
        drive_sel        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next = illegal ? ERR : SETUP;
                end
            end
            SETUP: begin
                drive_sel = 1'b1;
                if (mem_src) begin
                    mem_rd = 1'b1;
                    next   = WAIT;
                end else begin
                    next = LOAD;
                end
            end
            WAIT: begin
                drive_sel = 1'b1;
                if (wait_cnt == 4'd1) begin
                    next = LOAD;
                end
            end
            LOAD: begin
                drive_sel = 1'b1;
                ld_en     = dst_q[5:0];
                mem_wr    = dst_q[6];
                done      = 1'b1;
                next      = IDLE;
            end
            ERR: begin
                err  = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
        // Select is held constant from SETUP through LOAD so loads see a settled bus.
        if (drive_sel) begin
            if (mem_src) begin
                control_memory = src_q[0] ? 2'b10 : 2'b01;
            end else begin
                control_register = 6'd1 << src_q;
            end
        end
    end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Sequences single register-to-register and memory-to-register transfers over the shared 16-bit processor bus.
- Accepts one transfer request at a time from the instruction decoder (source code + destination load mask).
- Drives the bus mux selects (control_register / control_memory), then issues destination load enables once the bus has settled.
- Inserts MEM_LAT wait cycles for memory sources and handles DRAM write strobes.

Parameters:
- MEM_LAT, 2, wait cycles between mem_rd assertion and valid DRAM/IRAM data on the bus (legal 1..15).
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  transfer request strobe
- req_src  input  3  source code: 0=r 1=ar 2=dr 3=ac 4=pc 5=ir 6=dram 7=iram
- req_dst  input  7  destination load mask: bit0 r, 1 ar, 2 dr, 3 ac, 4 pc, 5 ir, 6 dram(write)
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
- control_register  output  6  one-hot bus select: bit0 r, 1 ar, 2 dr, 3 ac, 4 pc, 5 ir
- control_memory  output  2  one-hot bus select: bit0 dram, bit1 iram
- ld_en  output  6  register load enables, same bit order as req_dst[5:0]
- mem_rd  output  1  memory read strobe (address taken from ar)
- mem_wr  output  1  DRAM write strobe (address ar, data = bus)
- done  output  1  one-cycle pulse when a transfer completes
- err  output  1  one-cycle pulse when a request is rejected
- xfer_count  output  CNT_W  count of completed transfers

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0 except req_ready=1; xfer_count=0. A request in flight is discarded; no load or write is issued.
- The combined select {control_memory, control_register} is exactly one-hot from SETUP through LOAD, and all-zero in IDLE and ERR (bus then carries 0).
- IDLE, on accept:
  - Latch src and dst.
  - Illegal request if dst==0, or src==dram with dst[6]=1 (single-port DRAM). Go to ERR.
  - Otherwise go to SETUP.
- ERR: err=1 for 1 cycle, no selects, loads or strobes; then IDLE.
- SETUP: drive the select for the latched src.
  - Register source: next state LOAD.
  - Memory source: mem_rd=1 this cycle only; wait counter loaded with MEM_LAT; next state WAIT.
- WAIT: hold select; decrement counter each cycle; go to LOAD when the counter reaches 1. Total WAIT cycles = MEM_LAT.
- LOAD: hold select.
  - ld_en = dst[5:0].
  - mem_wr = dst[6].
  - done=1.
  - xfer_count += 1, wrapping at 2^CNT_W−1 → 0.
  - Next state IDLE.
- Latency from accept edge to done:
  - Register source: 2 cycles (SETUP, LOAD).
  - Memory source: 2+MEM_LAT cycles.
  - req_ready returns the cycle after LOAD.
- Self-copy (src register also set in dst) is legal and reloads the same value.
- Multiple dst bits are legal: broadcast, all loads in the same LOAD cycle.
- req_valid while not in IDLE is ignored; it is not queued.
- req_src/req_dst changing after accept have no effect.
- Loads and mem_wr never assert in the same cycle as a select change.

Test Plan:
- Reg→reg: reset, req src=3(ac) dst=6'b000010 → control_register=6'b001000 for 2 cycles; ld_en=6'b000010 and done in the 2nd cycle; xfer_count=1; req_ready high the next cycle.
- DRAM read, MEM_LAT=2: src=6 dst=bit2(dr) → control_memory=2'b01 for 4 cycles; mem_rd only in cycle 1; ld_en=6'b000100 and done in cycle 4.
- DRAM write: src=0(r) dst=7'b1000000 → control_register=6'b000001; mem_wr=1 and ld_en=0 in the LOAD cycle.
- Illegal requests:
  - dst=0 → err pulse, no selects, xfer_count unchanged.
  - src=6 with dst[6]=1 → err pulse, no selects, xfer_count unchanged.
- Busy/broadcast: issue src=7(iram) dst=6'b110000 (pc, ir); hold req_valid with a new request during WAIT → second request ignored until req_ready; pc and ir loaded together.
- Reset mid-WAIT: assert reset_n=0 during WAIT → outputs immediately 0, no done/ld_en/mem_wr; after release req_ready=1 and xfer_count=0. Also preload xfer_count=16'hFFFF via transfers or force, then one transfer → wraps to 0.
